xadac_dcache_arbiter: RTL and testbench

Shares the single external data-cache port of the core (`ext_dcache_req_i`/`ext_dcache_rsp_o`) between `NumReq` xadac-side requesters, e.g. the AXI-to-dcache adapter's read and write paths. It does three things: round-robin arbitration with request locking, the dcache index/tag two-phase address protocol, and in-order routing of read data back to the issuing requester through an outstanding-ID FIFO. It sits between the xadac AXI adapters and the cva6 external dcache port.

---
 rtl/xadac_dcache_arbiter.sv | 175 +++++++++++++++++
 tb/tb_xadac_dcache_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xadac_dcache_arbiter.sv
// Round-robin arbiter sharing one cva6 external dcache port between xadac requesters.
// Handles request locking, the index/tag two-phase address, and in-order read-data routing.
module xadac_dcache_arbiter #(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned IndexWidth     = 12,
    parameter int unsigned TagWidth       = 52,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,

    input  logic [NumReq-1:0]               req_i,
    output logic [NumReq-1:0]               gnt_o,
    input  logic [NumReq*AddrWidth-1:0]     addr_i,
    input  logic [NumReq-1:0]               we_i,
    input  logic [NumReq*DataWidth-1:0]     wdata_i,
    input  logic [NumReq*DataWidth/8-1:0]   be_i,
    input  logic [NumReq*2-1:0]             size_i,
    output logic [NumReq-1:0]               rvalid_o,
    output logic [DataWidth-1:0]            rdata_o,

    output logic                            dc_data_req_o,
    output logic                            dc_data_we_o,
    output logic [IndexWidth-1:0]           dc_address_index_o,
    output logic [DataWidth-1:0]            dc_data_wdata_o,
    output logic [DataWidth/8-1:0]          dc_data_be_o,
    output logic [1:0]                      dc_data_size_o,
    output logic [TagWidth-1:0]             dc_address_tag_o,
    output logic                            dc_tag_valid_o,
    output logic                            dc_kill_req_o,
    input  logic                            dc_data_gnt_i,
    input  logic                            dc_data_rvalid_i,
    input  logic [DataWidth-1:0]            dc_data_rdata_i,

    output logic                            busy_o,
    output logic                            err_o
);

    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned IdW     = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW    = PtrW + 1;

    logic [IdW-1:0]       r_rr;
    logic                 r_lock;
    logic [IdW-1:0]       r_lock_id;
    logic [IdW-1:0]       r_fifo [MaxOutstanding];
    logic [PtrW-1:0]      r_wptr;
    logic [PtrW-1:0]      r_rptr;
    logic [CntW-1:0]      r_cnt;
    logic [TagWidth-1:0]  r_tag;
    logic                 r_tag_valid;
    logic                 r_err;

    logic [AddrWidth-1:0] w_addr  [NumReq];
    logic [DataWidth-1:0] w_wdata [NumReq];
    logic [BeWidth-1:0]   w_be    [NumReq];
    logic [1:0]           w_size  [NumReq];
    logic [IdW-1:0]       w_sel;
    logic                 w_found;
    logic                 w_sel_valid;
    logic                 w_sel_we;
    logic                 w_full;
    logic                 w_grant;
    logic                 w_push;
    logic                 w_pop;
    logic [AddrWidth-1:0] w_sel_addr;

    // Unpack the flattened per-requester payload buses
    always_comb begin
        for (int i = 0; i < int'(NumReq); i++) begin
            w_addr[i]  = addr_i[i*AddrWidth +: AddrWidth];
            w_wdata[i] = wdata_i[i*DataWidth +: DataWidth];
            w_be[i]    = be_i[i*BeWidth +: BeWidth];
            w_size[i]  = size_i[i*2 +: 2];
        end
    end

    // Winner: locked requester, else first request at or after rr (cyclic)
    always_comb begin
        int unsigned k;
        w_sel   = r_rr;
        w_found = 1'b0;
        k       = 0;
        if (r_lock) begin
            w_sel   = r_lock_id;
            w_found = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NumReq; i++) begin
                k = int'(r_rr) + i;
                if (k >= NumReq) k = k - NumReq;
                if (!w_found && req_i[k]) begin
                    w_sel   = IdW'(k);
                    w_found = 1'b1;
                end
            end
        end
    end

    assign w_sel_valid = w_found;
    assign w_sel_we    = we_i[w_sel];
    assign w_sel_addr  = w_addr[w_sel];
    assign w_full      = (r_cnt == CntW'(MaxOutstanding));

    // Reads wait while the outstanding-ID FIFO is full; writes always pass
    assign dc_data_req_o      = w_sel_valid & ~(~w_sel_we & w_full);
    assign dc_data_we_o       = w_sel_we;
    assign dc_address_index_o = w_sel_addr[IndexWidth-1:0];
    assign dc_data_wdata_o    = w_wdata[w_sel];
    assign dc_data_be_o       = w_be[w_sel];
    assign dc_data_size_o     = w_size[w_sel];
    assign dc_kill_req_o      = 1'b0;
    assign dc_address_tag_o   = r_tag;
    assign dc_tag_valid_o     = r_tag_valid;

    assign w_grant = dc_data_req_o & dc_data_gnt_i;
    assign gnt_o   = w_grant ? (NumReq'(1) << w_sel) : '0;

    assign w_push   = w_grant & ~w_sel_we;
    assign w_pop    = dc_data_rvalid_i & (r_cnt != '0);
    assign rvalid_o = w_pop ? (NumReq'(1) << r_fifo[r_rptr]) : '0;
    assign rdata_o  = dc_data_rdata_i;

    assign busy_o = (r_cnt != '0) | r_tag_valid;
    assign err_o  = r_err;

    // Arbitration pointer, lock and tag phase
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr        <= '0;
            r_lock      <= 1'b0;
            r_lock_id   <= '0;
            r_tag       <= '0;
            r_tag_valid <= 1'b0;
        end else begin
            r_tag_valid <= w_grant;
            if (w_grant) begin
                r_rr  <= (w_sel == IdW'(NumReq - 1)) ? '0 : w_sel + IdW'(1);
                r_tag <= w_sel_addr[AddrWidth-1:IndexWidth];
            end
            if (r_lock) begin
                r_lock <= ~w_grant;
            end else if (dc_data_req_o && !dc_data_gnt_i) begin
                r_lock    <= 1'b1;
                r_lock_id <= w_sel;
            end
        end
    end

    // Outstanding-read FIFO pointers, count and sticky error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PtrW'(1);
            if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CntW'(1);
                2'b01:   r_cnt <= r_cnt - CntW'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (dc_data_rvalid_i && (r_cnt == '0)) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_fifo[r_wptr] <= w_sel;
    end

endmodule

// File: tb/tb_xadac_dcache_arbiter.sv
// Randomized bench for xadac_dcache_arbiter checked against a queue-based reference model.
module tb_xadac_dcache_arbiter;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 64;
    localparam int unsigned IW = 12;
    localparam int unsigned TW = 52;
    localparam int unsigned DW = 64;
    localparam int unsigned MO = 4;
    localparam int unsigned BW = DW / 8;

    logic              clk_i;
    logic              rst_ni;
    logic [NR-1:0]     req_i;
    logic [NR-1:0]     gnt_o;
    logic [NR*AW-1:0]  addr_i;
    logic [NR-1:0]     we_i;
    logic [NR*DW-1:0]  wdata_i;
    logic [NR*BW-1:0]  be_i;
    logic [NR*2-1:0]   size_i;
    logic [NR-1:0]     rvalid_o;
    logic [DW-1:0]     rdata_o;
    logic              dc_data_req_o;
    logic              dc_data_we_o;
    logic [IW-1:0]     dc_address_index_o;
    logic [DW-1:0]     dc_data_wdata_o;
    logic [BW-1:0]     dc_data_be_o;
    logic [1:0]        dc_data_size_o;
    logic [TW-1:0]     dc_address_tag_o;
    logic              dc_tag_valid_o;
    logic              dc_kill_req_o;
    logic              dc_data_gnt_i;
    logic              dc_data_rvalid_i;
    logic [DW-1:0]     dc_data_rdata_i;
    logic              busy_o;
    logic              err_o;

    xadac_dcache_arbiter #(
        .NumReq(NR), .AddrWidth(AW), .IndexWidth(IW), .TagWidth(TW),
        .DataWidth(DW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
        .wdata_i(wdata_i), .be_i(be_i), .size_i(size_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .dc_data_req_o(dc_data_req_o), .dc_data_we_o(dc_data_we_o),
        .dc_address_index_o(dc_address_index_o), .dc_data_wdata_o(dc_data_wdata_o),
        .dc_data_be_o(dc_data_be_o), .dc_data_size_o(dc_data_size_o),
        .dc_address_tag_o(dc_address_tag_o), .dc_tag_valid_o(dc_tag_valid_o),
        .dc_kill_req_o(dc_kill_req_o), .dc_data_gnt_i(dc_data_gnt_i),
        .dc_data_rvalid_i(dc_data_rvalid_i), .dc_data_rdata_i(dc_data_rdata_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Per-requester pending transaction, held until granted
    logic [NR-1:0] p_req;
    logic [AW-1:0] p_addr  [NR];
    logic          p_we    [NR];
    logic [DW-1:0] p_wdata [NR];
    logic [BW-1:0] p_be    [NR];
    logic [1:0]    p_size  [NR];
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;

    // Reference model state
    int            m_rr;
    bit            m_lock;
    int            m_lock_id;
    int            m_q[$];
    bit            m_tagv;
    logic [TW-1:0] m_tag;
    bit            m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_lock = 0; m_lock_id = 0; m_q.delete();
        m_tagv = 0; m_tag = '0; m_err = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < int'(NR); i++) begin
            req_i[i]              = p_req[i];
            we_i[i]               = p_we[i];
            addr_i[i*AW +: AW]    = p_addr[i];
            wdata_i[i*DW +: DW]   = p_wdata[i];
            be_i[i*BW +: BW]      = p_be[i];
            size_i[i*2 +: 2]      = p_size[i];
        end
        dc_data_gnt_i    = d_gnt;
        dc_data_rvalid_i = d_rvalid;
        dc_data_rdata_i  = d_rdata;
    endtask

    task automatic new_txn(input int r, input bit we, input logic [AW-1:0] a);
        p_req[r]   = 1'b1;
        p_we[r]    = we;
        p_addr[r]  = a;
        p_wdata[r] = {$urandom, $urandom};
        p_be[r]    = BW'($urandom);
        p_size[r]  = 2'($urandom);
    endtask

    // One clock: drive, check against model, step model across the edge
    task automatic cycle();
        int  sel;
        bit  ereq;
        bit  granted;
        logic [63:0] egnt, erv;
        logic [AW-1:0] sa;
        drive();
        #1;
        sel = -1;
        if (m_lock) sel = m_lock_id;
        else begin
            for (int i = 0; i < int'(NR); i++) begin
                int k;
                k = (m_rr + i) % int'(NR);
                if (sel < 0 && p_req[k]) sel = k;
            end
        end
        ereq    = (sel >= 0) && !(!p_we[sel] && m_q.size() == int'(MO));
        granted = ereq && d_gnt;
        egnt    = granted ? (64'd1 << sel) : 64'd0;
        erv     = (d_rvalid && m_q.size() > 0) ? (64'd1 << m_q[0]) : 64'd0;
        chk("dc_data_req", 64'(dc_data_req_o), 64'(ereq));
        chk("gnt", 64'(gnt_o), egnt);
        if (ereq) begin
            sa = p_addr[sel];
            chk("index", 64'(dc_address_index_o), 64'(sa[IW-1:0]));
            chk("we", 64'(dc_data_we_o), 64'(p_we[sel]));
            chk("wdata", 64'(dc_data_wdata_o), 64'(p_wdata[sel]));
            chk("be", 64'(dc_data_be_o), 64'(p_be[sel]));
            chk("size", 64'(dc_data_size_o), 64'(p_size[sel]));
        end
        chk("rvalid", 64'(rvalid_o), erv);
        if (erv != 0) chk("rdata", 64'(rdata_o), 64'(d_rdata));
        chk("tag_valid", 64'(dc_tag_valid_o), 64'(m_tagv));
        if (m_tagv) chk("tag", 64'(dc_address_tag_o), 64'(m_tag));
        chk("busy", 64'(busy_o), 64'(m_q.size() != 0 || m_tagv));
        chk("err", 64'(err_o), 64'(m_err));
        chk("kill", 64'(dc_kill_req_o), 64'd0);
        @(posedge clk_i);
        if (d_rvalid) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            else m_err = 1;
        end
        if (m_lock) m_lock = !granted;
        else if (ereq && !d_gnt) begin
            m_lock = 1; m_lock_id = sel;
        end
        m_tagv = granted;
        if (granted) begin
            sa     = p_addr[sel];
            m_tag  = sa[AW-1:IW];
            m_rr   = (sel + 1) % int'(NR);
            if (!p_we[sel]) m_q.push_back(sel);
            p_req[sel] = 1'b0;
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_err"}, 64'(err_o), 64'd0);
        chk({tag, "_tagv"}, 64'(dc_tag_valid_o), 64'd0);
        chk({tag, "_gnt"}, 64'(gnt_o), 64'd0);
        chk({tag, "_rvalid"}, 64'(rvalid_o), 64'd0);
        chk({tag, "_req"}, 64'(dc_data_req_o), 64'd0);
    endtask

    initial begin
        int pr [4] = '{100, 60, 90, 70};
        int pg [4] = '{100, 40, 100, 80};
        int pv [4] = '{50, 40, 3, 60};
        int budget;

        p_req = '0; d_gnt = 0; d_rvalid = 0; d_rdata = '0;
        for (int i = 0; i < int'(NR); i++) begin
            p_addr[i] = '0; p_we[i] = 0; p_wdata[i] = '0; p_be[i] = '0; p_size[i] = '0;
        end
        model_reset();
        rst_ni = 1'b0;
        drive();
        #3;
        check_reset_outputs("reset");
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Single read of 0x8000_1234 from requester 0, immediate grant
        new_txn(0, 1'b0, 64'h0000_0000_8000_1234);
        d_gnt = 1;
        cycle();
        chk("single_tagv", 64'(dc_tag_valid_o), 64'd1);
        chk("single_tag", 64'(dc_address_tag_o), 64'h8_0001);
        d_rvalid = 1; d_rdata = 64'h0000_0000_DEAD_BEEF;
        cycle();
        d_rvalid = 0;

        // Randomized phases: fairness, lock, full FIFO with passing writes, ordering
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 300; c++) begin
                for (int r = 0; r < int'(NR); r++)
                    if (!p_req[r] && $urandom_range(99) < 32'(pr[ph]))
                        new_txn(r, $urandom_range(2) == 0, {$urandom, $urandom});
                d_gnt    = $urandom_range(99) < 32'(pg[ph]);
                d_rvalid = (m_q.size() > 0) && ($urandom_range(99) < 32'(pv[ph]));
                d_rdata  = {$urandom, $urandom};
                cycle();
            end
        end

        // Drain pending requests and outstanding reads
        budget = 200;
        while ((p_req != 0 || m_q.size() > 0) && budget > 0) begin
            d_gnt    = 1;
            d_rvalid = m_q.size() > 0;
            d_rdata  = {$urandom, $urandom};
            cycle();
            budget--;
        end
        chk("drain_timeout", 64'(budget > 0), 64'd1);

        // Response with empty FIFO sets sticky error
        d_gnt = 0; d_rvalid = 1; d_rdata = 64'h1234;
        cycle();
        d_rvalid = 0;
        cycle();
        cycle();

        // Two outstanding reads, then asynchronous reset mid-operation
        new_txn(0, 1'b0, {$urandom, $urandom});
        new_txn(1, 1'b0, {$urandom, $urandom});
        d_gnt = 1;
        cycle();
        cycle();
        p_req = '0; d_gnt = 0; d_rvalid = 0;
        drive();
        chk("pre_reset_busy", 64'(busy_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("midreset");
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Stale response after reset is an error
        d_rvalid = 1; d_rdata = 64'h55;
        cycle();
        d_rvalid = 0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
